// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two cache ports, the arbiter
// and the memory side. The arbiter uses the slave view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]             req_valid_i;
    logic [1:0]             req_rw_i;
    logic [1:0][ADDR_W-1:0] req_addr_i;
    logic [1:0][DATA_W-1:0] req_wdata_i;
    logic [1:0]             req_ready_o;
    logic [DATA_W-1:0]      req_rdata_o;
    logic                   mem_valid_o;
    logic                   mem_rw_o;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic [DATA_W-1:0]      mem_wdata_o;
    logic                   mem_ready_i;
    logic [DATA_W-1:0]      mem_rdata_i;
    logic                   grant_o;
    logic                   busy_o;

    modport slave (
        input  req_valid_i, req_rw_i, req_addr_i, req_wdata_i,
        input  mem_ready_i, mem_rdata_i,
        output req_ready_o, req_rdata_o,
        output mem_valid_o, mem_rw_o, mem_addr_o, mem_wdata_o,
        output grant_o, busy_o
    );

    modport master (
        output req_valid_i, req_rw_i, req_addr_i, req_wdata_i,
        output mem_ready_i, mem_rdata_i,
        input  req_ready_o, req_rdata_o,
        input  mem_valid_o, mem_rw_o, mem_addr_o, mem_wdata_o,
        input  grant_o, busy_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (I$/D$) round-robin memory arbiter with one pending slot per port.
// Define ARB_WB_LOCK_EN to keep the grant on a port after its write-back.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic      clk_i,
    input logic      rst_i,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]             state;
    logic [1:0]             pending;
    logic [1:0]             slot_rw;
    logic [1:0][ADDR_W-1:0] slot_addr;
    logic [1:0][DATA_W-1:0] slot_wdata;
    logic                   grant;
    logic                   last_grant;
    logic                   iss_rw;
    logic [ADDR_W-1:0]      iss_addr;
    logic [DATA_W-1:0]      iss_wdata;
    logic                   busy;
    logic                   done;
    logic                   sel;
    logic [1:0]             accept;

    assign busy = (state != IDLE) && !rst_i;
    assign done = busy && bus.mem_ready_i;

    // The owner may only post its next request in its completion cycle.
    assign accept[0] = bus.req_valid_i[0] && !pending[0]
                     && !(busy && !grant && !done);
    assign accept[1] = bus.req_valid_i[1] && !pending[1]
                     && !(busy && grant && !done);

`ifdef ARB_WB_LOCK_EN
    logic lock_vld;
    logic lock_port;

    always_comb begin
        sel = pending[1];
        if (lock_vld && pending[lock_port])
            sel = lock_port;
        else if (&pending)
            sel = ~last_grant;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_vld  <= 1'b0;
            lock_port <= 1'b0;
        end else begin
            lock_vld  <= done && iss_rw && accept[grant];
            lock_port <= grant;
        end
    end
`else
    assign sel = (&pending) ? ~last_grant : pending[1];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            pending    <= 2'b00;
            slot_rw    <= '0;
            slot_addr  <= '0;
            slot_wdata <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            iss_rw     <= 1'b0;
            iss_addr   <= '0;
            iss_wdata  <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (accept[n]) begin
                    pending[n]    <= 1'b1;
                    slot_rw[n]    <= bus.req_rw_i[n];
                    slot_addr[n]  <= bus.req_addr_i[n];
                    slot_wdata[n] <= bus.req_wdata_i[n];
                end
            end
            case (state)
                IDLE: begin
                    if (|pending) begin
                        grant        <= sel;
                        iss_rw       <= slot_rw[sel];
                        iss_addr     <= slot_addr[sel];
                        iss_wdata    <= slot_wdata[sel];
                        pending[sel] <= 1'b0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (done) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (done) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = {done && grant, done && !grant};
    assign bus.req_rdata_o = bus.mem_rdata_i;
    assign bus.mem_valid_o = (state == ISSUE) && !rst_i;
    assign bus.mem_rw_o    = iss_rw;
    assign bus.mem_addr_o  = iss_addr;
    assign bus.mem_wdata_o = iss_wdata;
    assign bus.grant_o     = grant;
    assign bus.busy_o      = busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for
// mem_arbiter; expected values are worked out by hand.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic        r;
        logic [1:0]  v;
        logic [1:0]  rw;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        mr;
        logic [31:0] rd;
        logic        e_busy;
        logic        e_mv;
        logic [1:0]  e_rdy;
        logic        e_chk;
        logic        e_g;
        logic [31:0] e_addr;
    } vec_t;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    logic [AW-1:0] iss_q[$];
    vec_t tbl[$];

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h",
                      name, act, exp);
    endtask

    function automatic vec_t mk(
        input logic r, input logic [1:0] v, input logic [1:0] rw,
        input logic [31:0] a0, input logic [31:0] a1,
        input logic mr, input logic [31:0] rd,
        input logic eb, input logic emv, input logic [1:0] er,
        input logic ec, input logic eg, input logic [31:0] ea);
        vec_t t;
        t.r = r; t.v = v; t.rw = rw; t.a0 = a0; t.a1 = a1;
        t.mr = mr; t.rd = rd; t.e_busy = eb; t.e_mv = emv;
        t.e_rdy = er; t.e_chk = ec; t.e_g = eg; t.e_addr = ea;
        return t;
    endfunction

    task automatic log_issue();
        if (bus.mem_valid_o === 1'b1) iss_q.push_back(bus.mem_addr_o);
    endtask

    task automatic drive(input logic r, input logic [1:0] v,
                         input logic [1:0] rw,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic mr, input logic [31:0] rd);
        @(posedge clk_i);
        #1;
        rst_i             = r;
        bus.req_valid_i   = v;
        bus.req_rw_i      = rw;
        bus.req_addr_i[0] = a0;
        bus.req_addr_i[1] = a1;
        bus.mem_ready_i   = mr;
        bus.mem_rdata_i   = rd;
        #1;
        log_issue();
    endtask

    // Memory answers in WAIT; optionally both ports re-request then.
    task automatic step_auto(input logic rereq, output logic [1:0] rdy);
        logic mr;
        @(posedge clk_i);
        #1;
        mr = bus.busy_o && !bus.mem_valid_o;
        rst_i           = 1'b0;
        bus.req_valid_i = (rereq && mr) ? 2'b11 : 2'b00;
        bus.req_rw_i    = 2'b00;
        bus.mem_ready_i = mr;
        bus.mem_rdata_i = '0;
        #1;
        log_issue();
        rdy = bus.req_ready_o;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        iss_q.delete();
    endtask

    initial begin
        logic [1:0] rdy;
        logic       order[6];
        int         got;
        logic [31:0] exp_q[3];

        rst_i = 1'b1;
        bus.req_valid_i = '0;
        bus.req_rw_i    = '0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i[0] = 32'hA0A0_0000;
        bus.req_wdata_i[1] = 32'hB1B1_0000;
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;

        // reset with a stray ready
        tbl.push_back(mk(1,0,0,0,0,1,32'h1, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,     0,0,0,0,0,0));
        // single fill p0 @0x100
        tbl.push_back(mk(0,1,0,32'h100,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,       0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,       1,1,0,1,0,32'h100));
        tbl.push_back(mk(0,0,0,0,0,0,0,       1,0,0,1,0,32'h100));
        tbl.push_back(mk(0,0,0,0,0,0,0,       1,0,0,1,0,32'h100));
        tbl.push_back(mk(0,0,0,0,0,1,32'hDEADBEEF,
                         1,0,2'b01,1,0,32'h100));
        tbl.push_back(mk(0,0,0,0,0,0,0,       0,0,0,0,0,0));
        // ready in IDLE is ignored
        tbl.push_back(mk(0,0,0,0,0,1,32'h33,  0,0,0,0,0,0));
        // simultaneous after reset
        tbl.push_back(mk(1,0,0,0,0,0,0,       0,0,0,0,0,0));
        tbl.push_back(mk(0,3,0,32'h10,32'h20,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,       0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,       1,1,0,1,0,32'h10));
        tbl.push_back(mk(0,0,0,0,0,1,32'h11,  1,0,2'b01,1,0,32'h10));
        tbl.push_back(mk(0,0,0,0,0,0,0,       0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'h22,  1,1,2'b10,1,1,32'h20));
        tbl.push_back(mk(0,0,0,0,0,0,0,       0,0,0,0,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].rw, tbl[i].a0,
                  tbl[i].a1, tbl[i].mr, tbl[i].rd);
            check($sformatf("v%0d busy", i), bus.busy_o, tbl[i].e_busy);
            check($sformatf("v%0d mvalid", i), bus.mem_valid_o,
                  tbl[i].e_mv);
            check($sformatf("v%0d ready", i), bus.req_ready_o,
                  tbl[i].e_rdy);
            check($sformatf("v%0d rdata", i), bus.req_rdata_o,
                  tbl[i].rd);
            if (tbl[i].e_chk) begin
                check($sformatf("v%0d grant", i), bus.grant_o,
                      tbl[i].e_g);
                check($sformatf("v%0d addr", i), bus.mem_addr_o,
                      tbl[i].e_addr);
            end
        end

        // fairness over six back-to-back transactions
        do_reset();
        drive(0, 3, 0, 32'h1000, 32'h2000, 0, 0);
        got = 0;
        for (int c = 0; c < 200 && got < 6; c++) begin
            step_auto(1'b1, rdy);
            if (rdy != 2'b00) begin
                order[got] = rdy[1];
                got++;
            end
        end
        check("fair count", got, 6);
        for (int k = 0; k < got; k++)
            check($sformatf("fair grant%0d", k), order[k], k % 2);

        // write-back then fill from the same port
        do_reset();
        drive(0, 2'b10, 2'b10, 0, 32'h40, 0, 0);
        drive(0, 2'b01, 2'b00, 32'h200, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("wb rw", bus.mem_rw_o, 1);
        check("wb wdata", bus.mem_wdata_o, 32'hB1B1_0000);
        drive(0, 2'b10, 2'b00, 0, 32'h80, 1, 0);
        check("wb ready", bus.req_ready_o, 2'b10);
        for (int c = 0; c < 50 && iss_q.size() < 3; c++)
            step_auto(1'b0, rdy);
`ifdef ARB_WB_LOCK_EN
        exp_q = '{32'h40, 32'h80, 32'h200};
`else
        exp_q = '{32'h40, 32'h200, 32'h80};
`endif
        check("wb count", iss_q.size(), 3);
        for (int k = 0; k < 3 && k < iss_q.size(); k++)
            check($sformatf("wb order%0d", k), iss_q[k], exp_q[k]);

        // reset while waiting
        do_reset();
        drive(0, 3, 0, 32'h500, 32'h600, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rw busy", bus.busy_o, 1);
        drive(1, 0, 0, 0, 0, 1, 0);
        check("rw rst ready", bus.req_ready_o, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("rw ready", bus.req_ready_o, 0);
        check("rw idle", bus.busy_o, 0);
        iss_q.delete();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            check($sformatf("rw busy%0d", c), bus.busy_o, 0);
        end
        check("rw no issue", iss_q.size(), 0);

        // duplicate request from the owning port
        do_reset();
        drive(0, 1, 0, 32'h300, 0, 0, 0);
        drive(0, 1, 0, 32'h999, 0, 0, 0);
        drive(0, 1, 0, 32'h999, 0, 0, 0);
        check("dup mvalid", bus.mem_valid_o, 1);
        check("dup addr", bus.mem_addr_o, 32'h300);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("dup hold", bus.mem_addr_o, 32'h300);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("dup ready", bus.req_ready_o, 2'b01);
        for (int c = 0; c < 5; c++)
            drive(0, 0, 0, 0, 0, 0, 0);
        check("dup count", iss_q.size(), 1);
        if (iss_q.size() > 0)
            check("dup q addr", iss_q[0], 32'h300);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
